// File: rtl/spart_rx.sv
// -----------------------------------------------------------------------------
// spart_rx -- SPART serial receive stage.
//
// Deserializes an asynchronous start/data/stop frame from rxd into a parallel
// byte using the 16x-oversampled rx_enable tick from the baud rate generator.
// Every FSM and datapath step advances only on rx_enable. The input
// synchronizer and the clr_rda status-clear path run on every clk.
//
// Parameters:
//   DATA_BITS   data bits per frame, LSB first (2..8, bit counter is 3 bits)
//   OVERSAMPLE  rx_enable ticks per bit period (power of two, >= 8)
//
// Ports:
//   clk          in   system clock (also clocks the baud rate generator)
//   rst          in   synchronous, active-high reset
//   rx_enable    in   one-clk tick at OVERSAMPLE x baud
//   rxd          in   asynchronous serial line, idles high
//   clr_rda      in   one-clk strobe: CPU has read the receive buffer
//   rx_data      out  last received byte
//   rda          out  receive data available
//   framing_err  out  last byte had a stop bit of 0
//   overrun_err  out  a byte was loaded while rda was still set
//   busy         out  receiver is outside IDLE
// -----------------------------------------------------------------------------
module spart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_enable,
  input  logic                 rxd,
  input  logic                 clr_rda,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rda,
  output logic                 framing_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);

  // Mid start bit is half a bit period after the detected falling edge; from
  // there every sample point is a full bit period later.
  localparam logic [TW-1:0] MID_START = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] MID_BIT   = TW'(OVERSAMPLE - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  state_e                 state_q,       state_d;
  logic                   rxd_meta_q,    rxd_meta_d;
  logic                   rxd_s_q,       rxd_s_d;
  logic [TW-1:0]          tick_cnt_q,    tick_cnt_d;
  logic [2:0]             bit_cnt_q,     bit_cnt_d;
  logic [DATA_BITS-1:0]   shreg_q,       shreg_d;
  logic [DATA_BITS-1:0]   rx_data_q,     rx_data_d;
  logic                   rda_q,         rda_d;
  logic                   framing_err_q, framing_err_d;
  logic                   overrun_err_q, overrun_err_d;
  logic                   load;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d       = state_q;
    rxd_meta_d    = rxd;
    rxd_s_d       = rxd_meta_q;
    tick_cnt_d    = tick_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shreg_d       = shreg_q;
    rx_data_d     = rx_data_q;
    rda_d         = rda_q;
    framing_err_d = framing_err_q;
    overrun_err_d = overrun_err_q;
    load          = 1'b0;

    if (rx_enable) begin
      tick_cnt_d = tick_cnt_q + TW'(1);
      unique case (state_q)
        S_IDLE: begin
          tick_cnt_d = '0;
          if (!rxd_s_q) state_d = S_START;
        end
        S_START: begin
          if (tick_cnt_q == MID_START) begin
            tick_cnt_d = '0;
            if (rxd_s_q) begin
              // Glitch shorter than half a bit: drop it, flags untouched.
              state_d = S_IDLE;
            end else begin
              state_d   = S_DATA;
              bit_cnt_d = '0;
            end
          end
        end
        S_DATA: begin
          // tick_cnt wraps from MID_BIT to 0 on its own, so the next sample
          // lands exactly one bit period later without an explicit clear.
          if (tick_cnt_q == MID_BIT) begin
            shreg_d   = {rxd_s_q, shreg_q[DATA_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == LAST_BIT) state_d = S_STOP;
          end
        end
        S_STOP: begin
          if (tick_cnt_q == MID_BIT) begin
            load    = 1'b1;
            // A low stop bit means the line may be held in break; wait for
            // it to rise so a stuck-low line cannot retrigger frames.
            state_d = rxd_s_q ? S_IDLE : S_BREAK;
          end
        end
        S_BREAK: begin
          tick_cnt_d = '0;
          if (rxd_s_q) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (clr_rda) begin
      rda_d         = 1'b0;
      framing_err_d = 1'b0;
      overrun_err_d = 1'b0;
    end

    // A load in the same cycle as clr_rda wins: the new byte is reported,
    // and the CPU's read means the previous byte was not lost.
    if (load) begin
      rx_data_d     = shreg_q;
      rda_d         = 1'b1;
      framing_err_d = !rxd_s_q;
      overrun_err_d = rda_q && !clr_rda;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q       <= S_IDLE;
      rxd_meta_q    <= 1'b1;
      rxd_s_q       <= 1'b1;
      tick_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      shreg_q       <= '0;
      rx_data_q     <= '0;
      rda_q         <= 1'b0;
      framing_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rxd_meta_q    <= rxd_meta_d;
      rxd_s_q       <= rxd_s_d;
      tick_cnt_q    <= tick_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shreg_q       <= shreg_d;
      rx_data_q     <= rx_data_d;
      rda_q         <= rda_d;
      framing_err_q <= framing_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rda         = rda_q;
  assign framing_err = framing_err_q;
  assign overrun_err = overrun_err_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: doc/spart_rx.md
# spart_rx

Serial receive stage of the SPART. It consumes the 16x-oversampled `rx_enable` tick from the baud rate generator and deserializes an asynchronous 8N1 frame from the `rxd` pin into a parallel byte. It flags receive-data-available, framing error and overrun to the bus interface. All logic advances only on `rx_enable` ticks except the input synchronizer and the status-clear path.

## Interface
- `DATA_BITS`, default 8: data bits per frame, sent LSB first.
- `OVERSAMPLE`, default 16: `rx_enable` ticks per bit period; must be a power of two, at least 8.

Ports:
- `clk`  in  1  system clock, the same clock that drives the baud rate generator.
- `rst`  in  1  reset, synchronous and active-high.
- `rx_enable`  in  1  one-`clk` pulse at 16x the baud rate, driven by the baud rate generator.
- `rxd`  in  1  asynchronous serial line; idles high.
- `clr_rda`  in  1  one-`clk` strobe from the bus interface when the CPU reads the receive buffer.
- `rx_data`  out  DATA_BITS  last received byte.
- `rda`  out  1  receive data available.
- `framing_err`  out  1  last byte had a stop bit of 0.
- `overrun_err`  out  1  a byte was loaded while `rda` was still set.
- `busy`  out  1  high in every state except IDLE.

## Operation
- **Synchronizer:** two flops on `rxd`, both reset to 1. All FSM decisions use the synchronized value `rxd_s`.
- **Counters:**
  - `tick_cnt`, log2(OVERSAMPLE) bits, increments only on `rx_enable`.
  - `bit_cnt`, 3 bits.
  - Shift register, DATA_BITS wide, shifts right; the new bit enters at the MSB.
- **States and transitions** (evaluated only on `rx_enable`):
  - IDLE: if `rxd_s`=0, go to START and clear `tick_cnt`.
  - START: when `tick_cnt`=OVERSAMPLE/2-1 (mid start bit), check the line.
    - `rxd_s`=0: go to DATA, clear `tick_cnt` and `bit_cnt`.
    - `rxd_s`=1: false start. Return to IDLE and change no flags.
  - DATA: when `tick_cnt`=OVERSAMPLE-1 (mid bit), shift in `rxd_s` and increment `bit_cnt`. After bit DATA_BITS-1, go to STOP.
  - STOP: when `tick_cnt`=OVERSAMPLE-1, load `rx_data` from the shift register and set `rda`.
    - `framing_err` takes the value of `!rxd_s`.
    - `overrun_err` is set if `rda` was already 1 and `clr_rda` is not asserted in that cycle.
    - Next state is IDLE if `rxd_s`=1, otherwise BREAK.
  - BREAK: stay until `rxd_s`=1, then go to IDLE. This prevents a held-low line from retriggering frames.
- **Overrun:** the new byte overwrites `rx_data`.
- **`clr_rda`:** clears `rda`, `framing_err` and `overrun_err` on the next edge, in any state.
  - If `clr_rda` and a STOP load fall in the same cycle, the load wins: `rda`=1, `overrun_err`=0, `framing_err` reflects the new byte.
- **No ticks:** if `rx_enable` never pulses (generator not yet loaded), the FSM holds its state. The synchronizer and `clr_rda` still operate.
- **Reset values:** `rx_data`=0, `rda`=0, `framing_err`=0, `overrun_err`=0, `busy`=0, state IDLE, counters 0, shift register 0.

## Timing
- Start-edge detection latency is 2 `clk` cycles (synchronizer) plus up to one tick period.
- Data bits are sampled at tick 8 of each bit period, counted from the detected start.
- `rda`, `rx_data` and the error flags update on the `clk` edge that consumes the mid-stop-bit `rx_enable` tick. They are visible in the following cycle, about 9.5 bit periods after the start edge.
- `busy` rises in the cycle after IDLE is left. It falls in the cycle after IDLE is re-entered.
- `clr_rda` takes effect with a latency of 1 `clk`.
- Reset mid-frame:
  - The frame is abandoned.
  - All outputs return to their reset values on the next edge.
  - A partial frame is never reported.

## Test plan
All scenarios drive `rx_enable` every 4 `clk`, giving 64 `clk` per bit, unless stated otherwise.
- Send frame 0x55 (8N1) -> `rda`=1, `rx_data`=0x55, `framing_err`=0, `overrun_err`=0, `busy`=0 afterwards.
- Pull `rxd` low for 3 ticks only -> START aborts, `rda` stays 0, `busy` returns to 0 within 8 ticks.
- Send data 0xA3 with stop bit 0, then hold the line low for 40 ticks -> `rx_data`=0xA3, `rda`=1, `framing_err`=1. No further frame is reported until `rxd` goes high.
- Send 0x12 then 0x34 with no `clr_rda` -> `rx_data`=0x34, `overrun_err`=1. Then pulse `clr_rda` -> `rda`, `framing_err` and `overrun_err` are all 0 one cycle later.
- Assert `clr_rda` in the exact cycle of the second byte's load -> `rda`=1, `overrun_err`=0, `rx_data` equals the second byte.
- Assert `rst` during data bit 4 of a frame, then send 0xF0 -> all outputs are 0 after reset, then `rx_data`=0xF0, `rda`=1. Repeat with `rx_enable` every 41 `clk` (the generator's default divisor) and get the same result.
